// File: rtl/regfile_scoreboard.sv
// Per-register in-flight writer counters for DE hazard detection; stall_o/issue_o are combinational, counts update next cycle.
// Backpressure: stall_o holds DE on a pending source or a saturated destination counter; same-cycle WB releases a hazard.
module regfile_scoreboard #(
   parameter int NREGS     = 32,
   parameter int REGNOBITS = 5,
   parameter int CNTBITS   = 2
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 issue_valid_i,
   input  logic                 issue_wr_i,
   input  logic [REGNOBITS-1:0] issue_rd_i,
   input  logic                 src1_valid_i,
   input  logic [REGNOBITS-1:0] src1_no_i,
   input  logic                 src2_valid_i,
   input  logic [REGNOBITS-1:0] src2_no_i,
   input  logic                 wb_valid_i,
   input  logic [REGNOBITS-1:0] wb_no_i,
   input  logic                 flush_i,
   output logic                 stall_o,
   output logic                 issue_o,
   output logic [NREGS-1:0]     busy_vec_o,
   output logic                 err_o,
   output logic [31:0]          stall_cycles_o
);

   localparam logic [CNTBITS-1:0] CNT_MAX = '1;

   logic [CNTBITS-1:0] count [NREGS];
   logic [NREGS-1:0]   busy_eff;
   logic               rd_full;
   logic               inc;
   logic               dec;
   logic               same_reg;

   // A counter about to drop to zero from this cycle's WB is not a hazard:
   // the regfile writes on negedge, so DE reads the fresh value.
   always_comb begin
      busy_eff   = '0;
      busy_vec_o = '0;
      for (int r = 1; r < NREGS; r++) begin
         busy_vec_o[r] = (count[r] != '0);
         busy_eff[r]   = (count[r] != '0) &&
                         !(wb_valid_i && (wb_no_i == REGNOBITS'(r)) && (count[r] == CNTBITS'(1)));
      end
   end

   assign rd_full  = issue_wr_i && (issue_rd_i != '0) && (count[issue_rd_i] == CNT_MAX);
   assign stall_o  = issue_valid_i && !flush_i &&
                     ((src1_valid_i && busy_eff[src1_no_i]) ||
                      (src2_valid_i && busy_eff[src2_no_i]) ||
                      rd_full);
   assign issue_o  = issue_valid_i && !stall_o;
   assign inc      = issue_o && issue_wr_i && (issue_rd_i != '0);
   assign dec      = wb_valid_i && (wb_no_i != '0);
   assign same_reg = (issue_rd_i == wb_no_i);

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int r = 0; r < NREGS; r++) count[r] <= '0;
         err_o          <= 1'b0;
         stall_cycles_o <= '0;
      end else begin
         if (stall_o && (stall_cycles_o != 32'hFFFF_FFFF))
            stall_cycles_o <= stall_cycles_o + 32'd1;
         if (flush_i) begin
            for (int r = 0; r < NREGS; r++) count[r] <= '0;
         end else if (!(inc && dec && same_reg)) begin
            if (inc)
               count[issue_rd_i] <= count[issue_rd_i] + CNTBITS'(1);
            if (dec) begin
               // Releasing an idle register means a WB with no matching issue.
               if (count[wb_no_i] == '0)
                  err_o <= 1'b1;
               else
                  count[wb_no_i] <= count[wb_no_i] - CNTBITS'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed hazard scenarios followed by random traffic, checked against a per-register pending-count model.
module tb_regfile_scoreboard;

   logic        clk = 1'b0;
   logic        reset;
   logic        iv, iw, s1v, s2v, wv, fl;
   logic [4:0]  rd, s1, s2, wn;
   logic        stall_o, issue_o, err_o;
   logic [31:0] busy_vec_o, stall_cycles_o;

   int              mcnt [32];
   bit              merr;
   longint unsigned mstall;
   int              npass  = 0;
   int              ntotal = 0;

   always #5 clk = ~clk;

   regfile_scoreboard #(.NREGS(32), .REGNOBITS(5), .CNTBITS(2)) dut (
      .clk(clk), .reset(reset),
      .issue_valid_i(iv), .issue_wr_i(iw), .issue_rd_i(rd),
      .src1_valid_i(s1v), .src1_no_i(s1), .src2_valid_i(s2v), .src2_no_i(s2),
      .wb_valid_i(wv), .wb_no_i(wn), .flush_i(fl),
      .stall_o(stall_o), .issue_o(issue_o), .busy_vec_o(busy_vec_o),
      .err_o(err_o), .stall_cycles_o(stall_cycles_o)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ntotal++;
      assert (obs === exp) npass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // A source is a hazard if someone is still going to write it after this cycle's WB.
   function automatic bit src_pending(input int r);
      int left;
      if (r == 0) return 1'b0;
      left = mcnt[r];
      if (wv && int'(wn) == r) left = left - 1;
      return left > 0;
   endfunction

   function automatic bit model_stall();
      bit hz;
      hz = (s1v && src_pending(int'(s1))) || (s2v && src_pending(int'(s2))) ||
           (iw && rd != 0 && mcnt[rd] >= 3);
      return iv && !fl && hz;
   endfunction

   function automatic logic [31:0] model_busy();
      logic [31:0] v;
      for (int r = 0; r < 32; r++) v[r] = (mcnt[r] > 0);
      return v;
   endfunction

   task automatic model_step(input bit st);
      int delta [32];
      if (reset) begin
         for (int r = 0; r < 32; r++) mcnt[r] = 0;
         merr   = 0;
         mstall = 0;
         return;
      end
      if (st && mstall < 64'hFFFF_FFFF) mstall++;
      if (fl) begin
         for (int r = 0; r < 32; r++) mcnt[r] = 0;
         return;
      end
      for (int r = 0; r < 32; r++) delta[r] = 0;
      if (iv && !st && iw && rd != 0) delta[rd] += 1;
      if (wv && wn != 0) begin
         if (delta[wn] == 1) delta[wn] = 0;
         else if (mcnt[wn] == 0) merr = 1;
         else delta[wn] = -1;
      end
      for (int r = 0; r < 32; r++) mcnt[r] += delta[r];
   endtask

   task automatic cycle();
      bit st;
      #2;
      st = model_stall();
      chk("stall_o", {31'd0, stall_o}, {31'd0, st});
      chk("issue_o", {31'd0, issue_o}, {31'd0, iv && !st});
      chk("busy_vec_o", busy_vec_o, model_busy());
      chk("err_o", {31'd0, err_o}, {31'd0, merr});
      chk("stall_cycles_o", stall_cycles_o, mstall[31:0]);
      model_step(st);
      @(posedge clk);
      #1;
   endtask

   task automatic set_in(input bit v, input bit w, input int d, input bit a1, input int n1,
                         input bit a2, input int n2, input bit b, input int bn, input bit f);
      iv = v; iw = w; rd = 5'(d); s1v = a1; s1 = 5'(n1); s2v = a2; s2 = 5'(n2);
      wv = b; wn = 5'(bn); fl = f;
   endtask

   initial begin
      reset = 1'b1;
      set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      for (int r = 0; r < 32; r++) mcnt[r] = 0;
      merr = 0; mstall = 0;
      repeat (2) @(posedge clk);
      #1;
      // Reset state with an idle-free issue request.
      set_in(1, 1, 5, 1, 5, 1, 6, 0, 0, 0);
      #1; chk("reset_issue", {31'd0, issue_o}, 32'd1);
      cycle();
      reset = 1'b0;

      // 1: issue x5 then consume x5.
      set_in(1, 1, 5, 0, 0, 0, 0, 0, 0, 0); cycle();
      set_in(1, 0, 0, 1, 5, 0, 0, 0, 0, 0);
      #1; chk("t1_stall", {31'd0, stall_o}, 32'd1);
      chk("t1_busy5", {31'd0, busy_vec_o[5]}, 32'd1);
      chk("t1_issue", {31'd0, issue_o}, 32'd0);
      cycle();
      // 2: same-cycle WB frees the consumer.
      set_in(1, 0, 0, 1, 5, 0, 0, 1, 5, 0);
      #1; chk("t2_stall", {31'd0, stall_o}, 32'd0);
      chk("t2_issue", {31'd0, issue_o}, 32'd1);
      cycle();
      chk("t2_busy5_after", {31'd0, busy_vec_o[5]}, 32'd0);

      // 3: x0 is never tracked.
      set_in(1, 1, 0, 0, 0, 0, 0, 0, 0, 0); cycle();
      set_in(1, 0, 0, 1, 0, 1, 0, 0, 0, 0);
      #1; chk("t3_busy", busy_vec_o, 32'd0);
      chk("t3_stall", {31'd0, stall_o}, 32'd0);
      cycle();

      // 4: saturate x7 at three writers.
      for (int k = 0; k < 3; k++) begin
         set_in(1, 1, 7, 0, 0, 0, 0, 0, 0, 0); cycle();
      end
      set_in(1, 1, 7, 0, 0, 0, 0, 0, 0, 0);
      #1; chk("t4_full_stall", {31'd0, stall_o}, 32'd1);
      cycle();
      set_in(0, 0, 0, 0, 0, 0, 0, 1, 7, 0); cycle();
      set_in(1, 1, 7, 0, 0, 0, 0, 0, 0, 0);
      #1; chk("t4_accept", {31'd0, issue_o}, 32'd1);
      cycle();
      for (int k = 0; k < 3; k++) begin
         set_in(0, 0, 0, 0, 0, 0, 0, 1, 7, 0); cycle();
      end

      // 5: flush drops pending writers; a late WB is flagged.
      set_in(1, 1, 3, 0, 0, 0, 0, 0, 0, 0); cycle(); cycle();
      set_in(1, 1, 4, 0, 0, 0, 0, 1, 3, 1); cycle();
      chk("t5_busy_after_flush", busy_vec_o, 32'd0);
      set_in(0, 0, 0, 0, 0, 0, 0, 1, 3, 0); cycle();
      chk("t5_err", {31'd0, err_o}, 32'd1);

      // 6: stall counter, then reset mid-stall.
      reset = 1'b1; set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); cycle();
      reset = 1'b0;
      set_in(1, 1, 9, 0, 0, 0, 0, 0, 0, 0); cycle();
      set_in(1, 0, 0, 1, 9, 0, 0, 0, 0, 0);
      for (int k = 0; k < 10; k++) cycle();
      chk("t6_stall_cycles", stall_cycles_o, 32'd10);
      reset = 1'b1; cycle();
      reset = 1'b0;
      #1; chk("t6_busy_rst", busy_vec_o, 32'd0);
      chk("t6_cycles_rst", stall_cycles_o, 32'd0);
      chk("t6_stall_rst", {31'd0, stall_o}, 32'd0);
      chk("t6_issue_rst", {31'd0, issue_o}, 32'd1);
      cycle();

      // Random traffic over a small register window to create frequent hazards.
      for (int n = 0; n < 600; n++) begin
         reset = ($urandom_range(0, 99) == 0);
         set_in($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 7),
                $urandom_range(0, 1) == 1, $urandom_range(0, 7),
                $urandom_range(0, 1) == 1, $urandom_range(0, 7),
                $urandom_range(0, 2) == 0, $urandom_range(0, 7),
                $urandom_range(0, 24) == 0);
         cycle();
      end

      $display("%0d/%0d checks passed", npass, ntotal);
      $finish;
   end

endmodule
